mem_load_ctrl: RTL and testbench

MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

---
 rtl/mem_load_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_load_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_ctrl.sv
// Boot loader: streams words from a valid/ready source into the CPU's external
// memory write port while holding the CPU in reset, then releases it.
module mem_load_ctrl #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int RELEASE_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  load_len,
    input  logic [31:0] base_adr,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        ext_memwrite,
    output logic [31:0] ext_dataadr,
    output logic [31:0] ext_writedata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int HOLD_W = $clog2(RELEASE_CYC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

    state_t              state_reg, state_next;
    logic [9:0]          len_reg;
    logic [9:0]          idx_reg;
    logic [31:0]         base_reg;
    logic [TMO_W-1:0]    tmo_reg;
    logic [HOLD_W-1:0]   hold_reg;
    logic                done_reg;

    logic hs;
    logic start_ok;
    logic last_word;

    assign hs        = in_ready & in_valid;
    assign start_ok  = start && (state_reg == IDLE || state_reg == RUN || state_reg == ERR);
    assign last_word = (idx_reg == len_reg - 10'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_next = (load_len != 10'd0) ? LOAD : HOLD;
                end
            end
            LOAD: begin
                // The final handshake moves on immediately; its write lands during HOLD.
                if (hs && last_word) begin
                    state_next = HOLD;
                end else if (!hs && tmo_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_next = ERR;
                end
            end
            HOLD: begin
                if (hold_reg == HOLD_W'(RELEASE_CYC - 1)) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == LOAD) && (idx_reg < len_reg);
        busy      = (state_reg == LOAD) || (state_reg == HOLD);
        error     = (state_reg == ERR);
        cpu_reset = (state_reg != RUN);
        done      = done_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_reg       <= '0;
            idx_reg       <= '0;
            base_reg      <= '0;
            tmo_reg       <= '0;
            hold_reg      <= '0;
            done_reg      <= 1'b0;
            ext_memwrite  <= 1'b0;
            ext_dataadr   <= '0;
            ext_writedata <= '0;
        end else begin
            if (start_ok && load_len != 10'd0) begin
                len_reg  <= load_len;
                base_reg <= base_adr & ~32'h3;
                idx_reg  <= '0;
                tmo_reg  <= '0;
            end else if (state_reg == LOAD) begin
                if (hs) begin
                    idx_reg <= idx_reg + 10'd1;
                    tmo_reg <= '0;
                end else begin
                    tmo_reg <= tmo_reg + TMO_W'(1);
                end
            end

            hold_reg <= (state_reg == HOLD) ? hold_reg + HOLD_W'(1) : '0;
            done_reg <= (state_reg == HOLD) && (state_next == RUN);

            // Address and data hold their last values between strobes.
            ext_memwrite <= hs;
            if (hs) begin
                ext_dataadr   <= base_reg + {20'd0, idx_reg, 2'b00};
                ext_writedata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed checks of the boot loader: streaming, gaps, zero length, timeout,
// asynchronous reset, reload from RUN and address wrap.
module tb_mem_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  load_len;
    logic [31:0] base_adr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        ext_memwrite;
    logic [31:0] ext_dataadr;
    logic [31:0] ext_writedata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    mem_load_ctrl #(.TIMEOUT_CYC(8), .RELEASE_CYC(4)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .base_adr(base_adr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ext_memwrite(ext_memwrite), .ext_dataadr(ext_dataadr),
        .ext_writedata(ext_writedata), .cpu_reset(cpu_reset), .busy(busy),
        .done(done), .error(error)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        int          cyc;
    } wr_t;

    wr_t  wq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   fall_cyc = -1;
    logic prev_cr = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ext_memwrite) begin
            wr_t w;
            w.adr = ext_dataadr;
            w.dat = ext_writedata;
            w.cyc = cyc;
            wq.push_back(w);
            $display("write cyc=%0d adr=%h data=%h", cyc, ext_dataadr, ext_writedata);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_cr && !cpu_reset) fall_cyc = cyc;
        prev_cr = cpu_reset;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        done_cnt = 0;
        done_cyc = -1;
        fall_cyc = -1;
    endtask

    task automatic do_start(input logic [9:0] len, input logic [31:0] base);
        load_len = len;
        base_adr = base;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        load_len = '0; base_adr = '0;
        #3;
        checks++;
        if ({cpu_reset, ext_memwrite, busy, done, error, in_ready} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=100000",
                     {cpu_reset, ext_memwrite, busy, done, error, in_ready});
        end
        checks++;
        if ({ext_dataadr, ext_writedata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_bus got adr=%h data=%h exp 0/0", ext_dataadr, ext_writedata);
        end
        tick(2);
        reset = 1'b1;
        tick(3);
        checks++;
        if ({cpu_reset, busy, in_ready, ext_memwrite} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=1000", {cpu_reset, busy, in_ready, ext_memwrite});
        end
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        logic [31:0] exp_d[3];
        exp_d[0] = 32'hA0A0_0001; exp_d[1] = 32'hB0B0_0002; exp_d[2] = 32'hC0C0_0003;
        clear_mon();
        do_start(10'd3, 32'h100);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = exp_d[i];
            tick();
        end
        in_valid = 1'b0;
        tick(8);
        checks++;
        if (wq.size() != 3) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=3", wq.size());
        end
        for (int i = 0; i < wq.size() && i < 3; i++) begin
            checks++;
            if (wq[i].adr !== 32'h100 + 32'(4 * i) || wq[i].dat !== exp_d[i] || wq[i].cyc != wq[0].cyc + i) begin
                errors++;
                $display("FAIL basic_write%0d got adr=%h data=%h cyc=%0d exp adr=%h data=%h cyc=%0d",
                         i, wq[i].adr, wq[i].dat, wq[i].cyc, 32'h100 + 32'(4 * i), exp_d[i], wq[0].cyc + i);
            end
        end
        if (wq.size() == 3) begin
            checks++;
            if (fall_cyc != wq[2].cyc + 4) begin
                errors++;
                $display("FAIL basic_release got=%0d exp=%0d", fall_cyc, wq[2].cyc + 4);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != fall_cyc || cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got cnt=%0d cyc=%0d cpu_reset=%b exp cnt=1 cyc=%0d cpu_reset=0",
                     done_cnt, done_cyc, cpu_reset, fall_cyc);
        end
        $display("test_basic complete");
    endtask

    task automatic test_toggle();
        int exp_c[$];
        clear_mon();
        do_start(10'd2, 32'h200);
        checks++;
        if ({cpu_reset, busy} !== 2'b11) begin
            errors++;
            $display("FAIL reload_reassert got=%b exp=11", {cpu_reset, busy});
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = 32'hB000_0000 + 32'(k / 2);
            if (in_valid) exp_c.push_back(cyc + 1);
            tick();
        end
        in_valid = 1'b0;
        tick(6);
        checks++;
        if (wq.size() != 2) begin
            errors++;
            $display("FAIL toggle_count got=%0d exp=2", wq.size());
        end
        for (int i = 0; i < wq.size() && i < 2; i++) begin
            checks++;
            if (wq[i].cyc != exp_c[i] || wq[i].adr !== 32'h200 + 32'(4 * i) || wq[i].dat !== 32'hB000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL toggle_write%0d got cyc=%0d adr=%h data=%h exp cyc=%0d adr=%h data=%h",
                         i, wq[i].cyc, wq[i].adr, wq[i].dat, exp_c[i], 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            end
        end
        $display("test_toggle complete");
    endtask

    task automatic test_zero_len();
        int s;
        clear_mon();
        do_start(10'd0, 32'h600);
        s = cyc;
        checks++;
        if ({busy, cpu_reset, in_ready} !== 3'b110) begin
            errors++;
            $display("FAIL zero_hold got=%b exp=110", {busy, cpu_reset, in_ready});
        end
        tick(8);
        checks++;
        if (wq.size() != 0 || fall_cyc != s + 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_release got writes=%0d fall=%0d done=%0d exp writes=0 fall=%0d done=1",
                     wq.size(), fall_cyc, done_cnt, s + 4);
        end
        $display("test_zero_len complete");
    endtask

    task automatic test_timeout();
        int n;
        clear_mon();
        do_start(10'd3, 32'h300);
        in_valid = 1'b1;
        in_data  = 32'hC0DE_0001;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!error && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL timeout_cycles got=%0d exp=8", n);
        end
        in_valid = 1'b1;
        tick(2);
        checks++;
        if ({error, cpu_reset, in_ready, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL err_state got=%b exp=1100", {error, cpu_reset, in_ready, busy});
        end
        in_valid = 1'b0;
        checks++;
        if (wq.size() != 1 || (wq.size() == 1 && (wq[0].adr !== 32'h300 || wq[0].dat !== 32'hC0DE_0001))) begin
            errors++;
            $display("FAIL timeout_write got count=%0d exp count=1 adr=00000300 data=c0de0001", wq.size());
        end
        clear_mon();
        do_start(10'd2, 32'h400);
        checks++;
        if ({error, busy} !== 2'b01) begin
            errors++;
            $display("FAIL err_recover got=%b exp=01", {error, busy});
        end
        in_valid = 1'b1;
        in_data  = 32'hD000_0001;
        tick();
        in_data  = 32'hD000_0002;
        tick();
        in_valid = 1'b0;
        tick(6);
        checks++;
        if (wq.size() != 2 || cpu_reset !== 1'b0 ||
            (wq.size() == 2 && (wq[1].adr !== 32'h404 || wq[1].dat !== 32'hD000_0002))) begin
            errors++;
            $display("FAIL recover_load got count=%0d cpu_reset=%b exp count=2 cpu_reset=0 last adr=00000404",
                     wq.size(), cpu_reset);
        end
        $display("test_timeout complete");
    endtask

    task automatic test_async_reset();
        clear_mon();
        do_start(10'd4, 32'h500);
        in_valid = 1'b1;
        in_data  = 32'hE000_0001;
        tick();
        checks++;
        if (ext_memwrite !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_strobe got=%b exp=1", ext_memwrite);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_reset, ext_memwrite, busy, done, error, in_ready} !== 6'b100000 ||
            ext_dataadr !== 32'd0 || ext_writedata !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got flags=%b adr=%h data=%h exp flags=100000 adr=0 data=0",
                     {cpu_reset, ext_memwrite, busy, done, error, in_ready}, ext_dataadr, ext_writedata);
        end
        in_valid = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(3);
        checks++;
        if (wq.size() != 0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle got writes=%0d busy=%b cpu_reset=%b exp 0/0/1", wq.size(), busy, cpu_reset);
        end
        clear_mon();
        do_start(10'd1, 32'h700);
        in_valid = 1'b1;
        in_data  = 32'hF000_0001;
        tick();
        in_valid = 1'b0;
        tick(6);
        do_start(10'd1, 32'h704);
        checks++;
        if (cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL run_restart got cpu_reset=%b exp=1", cpu_reset);
        end
        in_valid = 1'b1;
        in_data  = 32'hF000_0002;
        tick();
        in_valid = 1'b0;
        tick(6);
        checks++;
        if (wq.size() != 2 || done_cnt != 2 || cpu_reset !== 1'b0 ||
            (wq.size() == 2 && wq[1].adr !== 32'h704)) begin
            errors++;
            $display("FAIL reload_done got writes=%0d done=%0d cpu_reset=%b exp 2/2/0 last adr=00000704",
                     wq.size(), done_cnt, cpu_reset);
        end
        $display("test_async_reset complete");
    endtask

    task automatic test_wrap();
        clear_mon();
        do_start(10'd2, 32'hFFFF_FFFC);
        in_valid = 1'b1;
        in_data  = 32'h1111_1111;
        tick();
        in_data  = 32'h2222_2222;
        tick();
        in_valid = 1'b0;
        tick(6);
        checks++;
        if (wq.size() != 2 || (wq.size() == 2 && (wq[0].adr !== 32'hFFFF_FFFC || wq[1].adr !== 32'h0000_0000))) begin
            errors++;
            $display("FAIL wrap_addr got count=%0d exp adr fffffffc then 00000000", wq.size());
        end
        clear_mon();
        do_start(10'd1, 32'h103);
        in_valid = 1'b1;
        in_data  = 32'h3333_3333;
        tick();
        in_valid = 1'b0;
        tick(6);
        checks++;
        if (wq.size() != 1 || (wq.size() == 1 && wq[0].adr !== 32'h100)) begin
            errors++;
            $display("FAIL align_addr got count=%0d exp one write to 00000100", wq.size());
        end
        $display("test_wrap complete");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_zero_len();
        test_timeout();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
